// File: rtl/j68_bus_pkg.sv
// rtl/j68_bus_pkg.sv - shared state encoding, function codes and defaults for the j68 bus master
package j68_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_AS,
        S_DS,
        S_WAIT,
        S_DONE,
        S_REL
    } bus_state_t;

    localparam logic [2:0] FC_USER_DATA  = 3'd1;
    localparam logic [2:0] FC_USER_PROG  = 3'd2;
    localparam logic [2:0] FC_SUPER_DATA = 3'd5;
    localparam logic [2:0] FC_SUPER_PROG = 3'd6;
    localparam logic [2:0] FC_INT_ACK    = 3'd7;

    localparam int TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/sync.sv
// rtl/sync.sv - multi-flop synchronizer for asynchronous active-low bus inputs
module sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Resets to the negated (high) level so no spurious acknowledge is seen out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ff <= '1;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/j68_bus_master.sv
// rtl/j68_bus_master.sv - sequences j68 read/write requests into strobed 68000 bus cycles
module j68_bus_master
    import j68_bus_pkg::*;
#(
    parameter int ADDR_W      = 23,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rd_ena,
    input  logic              wr_ena,
    input  logic [1:0]        byte_ena,
    input  logic [ADDR_W-1:0] address,
    input  logic [15:0]       wr_data,
    input  logic [2:0]        fc_in,
    output logic              data_ack,
    output logic [15:0]       rd_data,
    output logic              bus_err,
    output logic [ADDR_W-1:0] addr,
    output logic [2:0]        FC,
    output logic              ASn,
    output logic              UDSn,
    output logic              LDSn,
    output logic              R_Wn,
    output logic [15:0]       data_out,
    output logic              data_oe,
    input  logic [15:0]       data_in,
    input  logic              DTACKn,
    input  logic              BERRn
);

    localparam logic [15:0] TO_LIM = TIMEOUT_CYC[15:0];

    bus_state_t        state, state_n;
    logic [15:0]       wait_cnt, cnt_n;
    logic              req_wr, wr_n;
    logic [1:0]        req_be, be_n;
    logic              err, err_n;
    logic              asn_n, udsn_n, ldsn_n, rwn_n, oe_n, ack_n, berr_n;
    logic [ADDR_W-1:0] addr_n;
    logic [2:0]        fc_n;
    logic [15:0]       dout_n, rdata_n;
    logic              dtack_s, berr_s;

    sync #(.STAGES(SYNC_STAGES)) u_sync_dtack (.clk(clk), .rstn(rstn), .d(DTACKn), .q(dtack_s));
    sync #(.STAGES(SYNC_STAGES)) u_sync_berr  (.clk(clk), .rstn(rstn), .d(BERRn),  .q(berr_s));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            req_wr   <= 1'b0;
            req_be   <= 2'b00;
            err      <= 1'b0;
            ASn      <= 1'b1;
            UDSn     <= 1'b1;
            LDSn     <= 1'b1;
            R_Wn     <= 1'b1;
            data_oe  <= 1'b0;
            data_ack <= 1'b0;
            bus_err  <= 1'b0;
            addr     <= '0;
            FC       <= 3'd0;
            data_out <= 16'd0;
            rd_data  <= 16'd0;
        end else begin
            state    <= state_n;
            wait_cnt <= cnt_n;
            req_wr   <= wr_n;
            req_be   <= be_n;
            err      <= err_n;
            ASn      <= asn_n;
            UDSn     <= udsn_n;
            LDSn     <= ldsn_n;
            R_Wn     <= rwn_n;
            data_oe  <= oe_n;
            data_ack <= ack_n;
            bus_err  <= berr_n;
            addr     <= addr_n;
            FC       <= fc_n;
            data_out <= dout_n;
            rd_data  <= rdata_n;
        end
    end

    // Next values are the registered outputs seen during the following state.
    always_comb begin
        state_n = state;
        cnt_n   = 16'd0;
        wr_n    = req_wr;
        be_n    = req_be;
        err_n   = err;
        asn_n   = ASn;
        udsn_n  = UDSn;
        ldsn_n  = LDSn;
        rwn_n   = R_Wn;
        oe_n    = data_oe;
        ack_n   = 1'b0;
        berr_n  = 1'b0;
        addr_n  = addr;
        fc_n    = FC;
        dout_n  = data_out;
        rdata_n = rd_data;
        case (state)
            S_IDLE: begin
                if (rd_ena || wr_ena) begin
                    wr_n    = wr_ena && !rd_ena;
                    be_n    = byte_ena;
                    err_n   = 1'b0;
                    addr_n  = address;
                    fc_n    = fc_in;
                    rwn_n   = !(wr_ena && !rd_ena);
                    if (wr_ena && !rd_ena) begin
                        dout_n = wr_data;
                    end
                    state_n = S_ADDR;
                end
            end
            S_ADDR: begin
                asn_n = 1'b0;
                if (req_wr) begin
                    oe_n = 1'b1;
                end else begin
                    udsn_n = !req_be[1];
                    ldsn_n = !req_be[0];
                end
                state_n = S_AS;
            end
            S_AS: begin
                if (req_wr) begin
                    udsn_n = !req_be[1];
                    ldsn_n = !req_be[0];
                end
                state_n = S_DS;
            end
            S_DS: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                // wait_cnt counts completed wait cycles and saturates rather than wrapping.
                cnt_n = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;
                if (!berr_s) begin
                    err_n   = 1'b1;
                    state_n = S_DONE;
                end else if (!dtack_s) begin
                    state_n = S_DONE;
                end else if (wait_cnt == TO_LIM) begin
                    err_n   = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                ack_n  = 1'b1;
                berr_n = err;
                if (!req_wr) begin
                    rdata_n = err ? 16'hFFFF : data_in;
                end
                asn_n   = 1'b1;
                udsn_n  = 1'b1;
                ldsn_n  = 1'b1;
                state_n = S_REL;
            end
            S_REL: begin
                oe_n = 1'b0;
                if (dtack_s && berr_s) begin
                    rwn_n   = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_j68_bus_master.sv
// tb/tb_j68_bus_master.sv - scoreboard bench for j68_bus_master bus cycle sequencing
module tb_j68_bus_master;
    import j68_bus_pkg::*;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rd_ena = 1'b0, wr_ena = 1'b0;
    logic [1:0]  byte_ena = 2'b00;
    logic [22:0] address = '0;
    logic [15:0] wr_data = '0;
    logic [2:0]  fc_in = '0;
    logic        data_ack, bus_err;
    logic [15:0] rd_data;
    logic [22:0] addr;
    logic [2:0]  FC;
    logic        ASn, UDSn, LDSn, R_Wn, data_oe;
    logic [15:0] data_out;
    logic [15:0] data_in = '0;
    logic        DTACKn = 1'b0, BERRn = 1'b1;

    j68_bus_master #(.ADDR_W(23), .SYNC_STAGES(2), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rstn(rstn), .rd_ena(rd_ena), .wr_ena(wr_ena), .byte_ena(byte_ena),
        .address(address), .wr_data(wr_data), .fc_in(fc_in), .data_ack(data_ack),
        .rd_data(rd_data), .bus_err(bus_err), .addr(addr), .FC(FC), .ASn(ASn), .UDSn(UDSn),
        .LDSn(LDSn), .R_Wn(R_Wn), .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
        .DTACKn(DTACKn), .BERRn(BERRn)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [16:0] sb[$];
    logic [16:0] exp_v;

    int tick = 0, rise_t = 0, last_gap = -1;
    logic asn_prev = 1'b1;
    always @(negedge clk) begin
        tick++;
        if (ASn && !asn_prev) rise_t = tick;
        if (!ASn && asn_prev) last_gap = tick - rise_t;
        asn_prev = ASn;
    end

    int r_as, r_uds, r_uds_rise, r_oe, r_oe_fall, r_ack, r_acks;
    logic r_lds_low, r_err, r_rwn;
    logic [15:0] r_data, r_dout;
    logic [22:0] r_addr;
    logic [2:0] r_fc;

    // Request enters at the current negedge (cycle 0); observes n cycles.
    task automatic run_req(input logic rd, input logic wr, input logic [1:0] be,
                           input logic [22:0] a, input logic [15:0] wd, input logic [2:0] fc,
                           input int n, input int drv_c, input logic drv_dt, input logic drv_be,
                           input int rel_c);
        r_as = -1; r_uds = -1; r_uds_rise = -1; r_oe = -1; r_oe_fall = -1; r_ack = -1;
        r_acks = 0; r_lds_low = 1'b0; r_err = 1'bx; r_rwn = 1'bx; r_data = 'x; r_dout = 'x;
        r_addr = 'x; r_fc = 'x;
        rd_ena = rd; wr_ena = wr; byte_ena = be; address = a; wr_data = wd; fc_in = fc;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == rel_c) begin DTACKn = 1'b1; BERRn = 1'b1; end
            if (i == drv_c) begin DTACKn = drv_dt; BERRn = drv_be; end
            if (!ASn && r_as < 0) begin r_as = i; r_addr = addr; r_fc = FC; end
            if (!UDSn && r_uds < 0) r_uds = i;
            if (UDSn && r_uds >= 0 && r_uds_rise < 0) r_uds_rise = i;
            if (!LDSn) r_lds_low = 1'b1;
            if (data_oe && r_oe < 0) begin r_oe = i; r_dout = data_out; end
            if (!data_oe && r_oe >= 0 && r_oe_fall < 0) r_oe_fall = i;
            if (data_ack) begin
                r_acks++;
                if (r_ack < 0) begin r_ack = i; r_data = rd_data; r_err = bus_err; r_rwn = R_Wn; end
                rd_ena = 1'b0; wr_ena = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if ({ASn, UDSn, LDSn, R_Wn, data_oe, data_ack, bus_err} !== 7'b1111000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 1111000", {ASn, UDSn, LDSn, R_Wn, data_oe, data_ack, bus_err}); end
        n_checks++; if ({addr, FC, rd_data, data_out} !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {addr, FC, rd_data, data_out}); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        data_in = 16'hBEEF;
        sb.push_back({1'b0, 16'hBEEF});
        run_req(1'b1, 1'b0, 2'b11, 23'h000400, 16'h0, FC_SUPER_DATA, 12, -1, 1'b0, 1'b0, 6);
        exp_v = sb.pop_front();
        n_checks++; if (r_as !== 2) begin n_fail++; $display("FAIL read_as_cycle: got %0d expected 2", r_as); end
        n_checks++; if (r_uds !== 2) begin n_fail++; $display("FAIL read_ds_cycle: got %0d expected 2", r_uds); end
        n_checks++; if (r_ack !== 6 || r_acks !== 1) begin n_fail++; $display("FAIL read_ack: got cycle %0d count %0d expected cycle 6 count 1", r_ack, r_acks); end
        n_checks++; if ({r_err, r_data} !== exp_v) begin n_fail++; $display("FAIL read_data: got %h expected %h", {r_err, r_data}, exp_v); end
        n_checks++; if (r_addr !== 23'h000400 || r_fc !== FC_SUPER_DATA || r_rwn !== 1'b1) begin n_fail++; $display("FAIL read_addr_fc: got %h/%0d/%b expected 000400/5/1", r_addr, r_fc, r_rwn); end
    endtask

    task automatic test_write();
        DTACKn = 1'b0;
        repeat (3) @(negedge clk);
        sb.push_back({1'b0, 16'hBEEF});
        run_req(1'b0, 1'b1, 2'b10, 23'h012345, 16'h1234, FC_USER_DATA, 12, -1, 1'b0, 1'b0, -1);
        exp_v = sb.pop_front();
        n_checks++; if (r_oe !== 2 || r_uds !== 3) begin n_fail++; $display("FAIL write_oe_before_uds: got oe %0d uds %0d expected 2 3", r_oe, r_uds); end
        n_checks++; if (r_lds_low !== 1'b0) begin n_fail++; $display("FAIL write_lds: got %b expected 0", r_lds_low); end
        n_checks++; if (r_uds_rise !== 6 || r_oe_fall !== 7) begin n_fail++; $display("FAIL write_release: got uds_rise %0d oe_fall %0d expected 6 7", r_uds_rise, r_oe_fall); end
        n_checks++; if (r_dout !== 16'h1234 || r_rwn !== 1'b0) begin n_fail++; $display("FAIL write_bus: got %h/%b expected 1234/0", r_dout, r_rwn); end
        n_checks++; if ({r_err, r_data} !== exp_v || r_ack !== 6) begin n_fail++; $display("FAIL write_ack: got %h at %0d expected %h at 6", {r_err, r_data}, r_ack, exp_v); end
        n_checks++; if (R_Wn !== 1'b0) begin n_fail++; $display("FAIL write_rwn_held: got %b expected 0", R_Wn); end
        DTACKn = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++; if (R_Wn !== 1'b1) begin n_fail++; $display("FAIL write_rwn_idle: got %b expected 1", R_Wn); end
    endtask

    task automatic test_timeout();
        sb.push_back({1'b1, 16'hFFFF});
        run_req(1'b1, 1'b0, 2'b11, 23'h000800, 16'h0, FC_USER_PROG, TO + 10, -1, 1'b0, 1'b0, -1);
        exp_v = sb.pop_front();
        n_checks++; if (r_ack !== TO + 6 || r_acks !== 1) begin n_fail++; $display("FAIL timeout_cycle: got %0d count %0d expected %0d count 1", r_ack, r_acks, TO + 6); end
        n_checks++; if ({r_err, r_data} !== exp_v) begin n_fail++; $display("FAIL timeout_data: got %h expected %h", {r_err, r_data}, exp_v); end
    endtask

    task automatic test_berr();
        sb.push_back({1'b1, 16'hFFFF});
        data_in = 16'h0F0F;
        run_req(1'b1, 1'b0, 2'b11, 23'h000010, 16'h0, FC_SUPER_DATA, 12, 4, 1'b0, 1'b0, -1);
        exp_v = sb.pop_front();
        n_checks++; if ({r_err, r_data} !== exp_v || r_ack !== 8) begin n_fail++; $display("FAIL berr_priority: got %h at %0d expected %h at 8", {r_err, r_data}, r_ack, exp_v); end
        data_in = 16'h5A5A;
        sb.push_back({1'b0, 16'h5A5A});
        run_req(1'b1, 1'b0, 2'b11, 23'h000020, 16'h0, FC_SUPER_DATA, 16, 7, 1'b0, 1'b1, 2);
        exp_v = sb.pop_front();
        n_checks++; if (r_as !== 7) begin n_fail++; $display("FAIL berr_hold_as: got %0d expected 7", r_as); end
        n_checks++; if ({r_err, r_data} !== exp_v || r_ack !== 11) begin n_fail++; $display("FAIL berr_next_read: got %h at %0d expected %h at 11", {r_err, r_data}, r_ack, exp_v); end
        DTACKn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        DTACKn = 1'b0;
        repeat (3) @(negedge clk);
        data_in = 16'h1357;
        sb.push_back({1'b0, 16'h1357});
        run_req(1'b1, 1'b1, 2'b11, 23'h000100, 16'hDEAD, FC_USER_DATA, 8, -1, 1'b0, 1'b0, 6);
        exp_v = sb.pop_front();
        n_checks++; if (r_rwn !== 1'b1 || r_oe !== -1) begin n_fail++; $display("FAIL both_read_only: got rwn %b oe %0d expected 1 -1", r_rwn, r_oe); end
        n_checks++; if ({r_err, r_data} !== exp_v || r_ack !== 6) begin n_fail++; $display("FAIL both_data: got %h at %0d expected %h at 6", {r_err, r_data}, r_ack, exp_v); end
        data_in = 16'h2468;
        sb.push_back({1'b0, 16'h2468});
        run_req(1'b1, 1'b0, 2'b01, 23'h000102, 16'h0, FC_USER_DATA, 16, 3, 1'b0, 1'b1, -1);
        exp_v = sb.pop_front();
        n_checks++; if (r_as !== 3 || last_gap < 2) begin n_fail++; $display("FAIL b2b_gap: got as %0d gap %0d expected as 3 gap >=2", r_as, last_gap); end
        n_checks++; if ({r_err, r_data} !== exp_v || r_ack !== 7) begin n_fail++; $display("FAIL b2b_data: got %h at %0d expected %h at 7", {r_err, r_data}, r_ack, exp_v); end
        DTACKn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        rd_ena = 1'b0; wr_ena = 1'b1; byte_ena = 2'b11; address = 23'h000200; wr_data = 16'hCAFE;
        repeat (6) @(negedge clk);
        n_checks++; if ({ASn, UDSn, LDSn, data_oe} !== 4'b0001) begin n_fail++; $display("FAIL mid_wait_strobes: got %b expected 0001", {ASn, UDSn, LDSn, data_oe}); end
        rstn = 1'b0;
        #1;
        n_checks++; if ({ASn, UDSn, LDSn, data_oe} !== 4'b1110) begin n_fail++; $display("FAIL async_reset: got %b expected 1110", {ASn, UDSn, LDSn, data_oe}); end
        wr_ena = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (data_ack) acks++;
        end
        n_checks++; if (acks !== 0 || ASn !== 1'b1) begin n_fail++; $display("FAIL post_reset_ack: got acks %0d asn %b expected 0 1", acks, ASn); end
        n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d expected 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_berr();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
